// File: rtl/lab_pkg.sv
// rtl/lab_pkg.sv - shared state encoding and default sizes for latch_bank_arbiter
package lab_pkg;

  localparam int LAB_N_REQ = 4;
  localparam int LAB_DW    = 8;
  localparam int LAB_NW    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ENABLE = 2'd2,
    ST_HOLD   = 2'd3
  } lab_state_e;

endpackage

// File: rtl/latch_word.sv
// rtl/latch_word.sv - DW-bit level-sensitive storage word with async active-low clear
module latch_word #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] D,
  input  logic          EN,
  input  logic          RST,
  output logic [DW-1:0] Q
);

  always_latch begin
    if (!RST) begin
      Q <= '0;
    end else if (EN) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/latch_bank_arbiter.sv
// rtl/latch_bank_arbiter.sv - arbitrated write port into a bank of latch words
// Optional build macro LAB_FIXED_PRIO_EN selects lowest-index-wins instead of round-robin.
module latch_bank_arbiter
  import lab_pkg::*;
#(
  parameter int N_REQ = LAB_N_REQ,
  parameter int DW    = LAB_DW,
  parameter int NW    = LAB_NW,
  parameter int AW    = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [N_REQ-1:0]    REQ,
  input  logic [N_REQ*DW-1:0] WDATA,
  input  logic [N_REQ*AW-1:0] WADDR,
  output logic [N_REQ-1:0]    GNT,
  output logic [N_REQ-1:0]    ACK,
  output logic                BUSY,
  output logic [NW*DW-1:0]    Q
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  lab_state_e        state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [NW-1:0]     en_q, en_d;
  logic [IW-1:0]     win_q, win_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [AW-1:0]     waddr_q, waddr_d;

  logic              found;
  logic [IW-1:0]     pick;

`ifdef LAB_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (REQ[i]) begin
        found = 1'b1;
        pick  = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] ptr_q, ptr_d;
  int            rr_idx;

  // Search starts at the pointer and wraps, so every requester is reached within N_REQ grants.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    rr_idx = 0;
    for (int i = 0; i < N_REQ; i++) begin
      rr_idx = (int'(ptr_q) + i) % N_REQ;
      if (!found && REQ[rr_idx]) begin
        found = 1'b1;
        pick  = IW'(rr_idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && found) begin
      ptr_d = (int'(pick) == N_REQ - 1) ? '0 : IW'(int'(pick) + 1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    ack_d   = '0;
    en_d    = '0;
    win_d   = win_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d     = ST_SETUP;
          gnt_d[pick] = 1'b1;
          win_d       = pick;
          wdata_d     = WDATA[int'(pick)*DW +: DW];
          waddr_d     = WADDR[int'(pick)*AW +: AW];
        end
      end
      ST_SETUP: begin
        state_d       = ST_ENABLE;
        en_d[waddr_q] = 1'b1;
      end
      ST_ENABLE: begin
        state_d      = ST_HOLD;
        ack_d[win_q] = 1'b1;
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      en_q    <= '0;
      win_q   <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      en_q    <= en_d;
      win_q   <= win_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
    end
  end

  // Enables come straight from en_q so the latch gates never see combinational glitches.
  for (genvar k = 0; k < NW; k++) begin : g_word
    latch_word #(.DW(DW)) u_word (
      .D  (wdata_q),
      .EN (en_q[k]),
      .RST(RST),
      .Q  (Q[k*DW +: DW])
    );
  end

  assign GNT  = gnt_q;
  assign ACK  = ack_q;
  assign BUSY = (state_q != ST_IDLE);

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// tb/tb_latch_bank_arbiter.sv - directed self-checking bench for latch_bank_arbiter
module tb_latch_bank_arbiter;
  import lab_pkg::*;

  logic        CLK;
  logic        RST;
  logic [3:0]  REQ;
  logic [31:0] WDATA;
  logic [7:0]  WADDR;
  logic [3:0]  GNT;
  logic [3:0]  ACK;
  logic        BUSY;
  logic [31:0] Q;

  int vecs;
  int errs;

  latch_bank_arbiter dut (
    .CLK  (CLK),
    .RST  (RST),
    .REQ  (REQ),
    .WDATA(WDATA),
    .WADDR(WADDR),
    .GNT  (GNT),
    .ACK  (ACK),
    .BUSY (BUSY),
    .Q    (Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  always @(negedge CLK) begin
    chk("en_only_in_enable", {63'd0, (dut.en_q == 4'd0) || (dut.state_q == ST_ENABLE)}, 64'd1);
    chk("gnt_onehot0", {63'd0, $onehot0(GNT)}, 64'd1);
    chk("ack_onehot0", {63'd0, $onehot0(ACK)}, 64'd1);
  end

  logic [3:0] exp_g;

  initial begin
    vecs  = 0;
    errs  = 0;
    RST   = 1'b0;
    REQ   = '0;
    WDATA = '0;
    WADDR = '0;
    repeat (2) @(negedge CLK);
    chk("rst_gnt", GNT, 0);
    chk("rst_ack", ACK, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_q", Q, 0);
    RST = 1'b1;

    // single write of 0xA5 to word 2 by requester 0
    @(negedge CLK);
    REQ   = 4'b0001;
    WDATA = 32'h0000_00A5;
    WADDR = 8'b0000_0010;
    @(negedge CLK);
    chk("s1_gnt", GNT, 4'b0001);
    chk("s1_busy", BUSY, 1);
    chk("s1_en_setup", dut.en_q, 0);
    REQ = 4'b0000;
    @(negedge CLK);
    chk("s1_en_enable", dut.en_q, 4'b0100);
    @(negedge CLK);
    chk("s1_ack", ACK, 4'b0001);
    chk("s1_gnt_hold", GNT, 0);
    chk("s1_q", Q, 32'h00A5_0000);
    @(negedge CLK);
    chk("s1_idle_busy", BUSY, 0);
    chk("s1_idle_ack", ACK, 0);

    // all four requesting continuously
    do_reset();
    REQ   = 4'b1111;
    WDATA = 32'h4433_2211;
    WADDR = {2'd3, 2'd2, 2'd1, 2'd0};
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
`ifdef LAB_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'b0001 << (k % 4);
`endif
      chk($sformatf("s2_gnt%0d", k), GNT, exp_g);
      if (k == 4) REQ = 4'b0000;
      repeat (2) @(negedge CLK);
      chk($sformatf("s2_ack%0d", k), ACK, exp_g);
      @(negedge CLK);
    end
`ifdef LAB_FIXED_PRIO_EN
    chk("s2_q", Q, 32'h0000_0011);
`else
    chk("s2_q", Q, 32'h4433_2211);
`endif

    // requesters 1 and 3 both target word 0
    do_reset();
    REQ   = 4'b1010;
    WDATA = 32'h3300_1100;
    WADDR = 8'h00;
    @(negedge CLK);
    chk("s3_gnt1", GNT, 4'b0010);
    REQ = 4'b1000;
    repeat (2) @(negedge CLK);
    chk("s3_ack1", ACK, 4'b0010);
    chk("s3_q1", Q, 32'h0000_0011);
    repeat (2) @(negedge CLK);
    chk("s3_gnt3", GNT, 4'b1000);
    REQ = 4'b0000;
    repeat (2) @(negedge CLK);
    chk("s3_ack3", ACK, 4'b1000);
    chk("s3_q3", Q, 32'h0000_0033);
    @(negedge CLK);

    // reset during ENABLE of 0xFF -> word 1 by requester 1
    do_reset();
    REQ   = 4'b0010;
    WDATA = 32'h0000_FF00;
    WADDR = 8'b0000_0100;
    @(negedge CLK);
    chk("s4_gnt", GNT, 4'b0010);
    REQ = 4'b0000;
    @(negedge CLK);
    chk("s4_en", dut.en_q, 4'b0010);
    RST = 1'b0;
    #1;
    chk("s4_rst_ack", ACK, 0);
    chk("s4_rst_q", Q, 0);
    chk("s4_rst_busy", BUSY, 0);
    chk("s4_rst_gnt", GNT, 0);
    @(negedge CLK);
    chk("s4_no_ack", ACK, 0);
    chk("s4_q_clear", Q, 0);
    RST = 1'b1;
    REQ = 4'b0101;
    WDATA = 32'h0000_0000;
    WADDR = 8'h00;
    @(negedge CLK);
    chk("s4_next_gnt", GNT, 4'b0001);
    REQ = 4'b0000;
    repeat (2) @(negedge CLK);
    chk("s4_next_ack", ACK, 4'b0001);
    @(negedge CLK);

    // requester 2 pulses during requester 0's transaction
    REQ   = 4'b0001;
    WDATA = 32'h0000_00C3;
    WADDR = 8'h00;
    @(negedge CLK);
    chk("s5_gnt0", GNT, 4'b0001);
    REQ = 4'b0100;
    @(negedge CLK);
    REQ = 4'b0000;
    @(negedge CLK);
    chk("s5_ack0", ACK, 4'b0001);
    chk("s5_q", Q, 32'h0000_00C3);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk($sformatf("s5_no_gnt%0d", k), GNT, 0);
      chk($sformatf("s5_no_ack%0d", k), ACK, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
